// File: rtl/icache_direct_if.sv
// Single-word refill bus between the instruction cache and the memory controller.
// The cache drives the request side; the controller answers with a one-cycle done pulse.
interface icache_direct_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_done,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_done,
    output mem_data
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache.
// A hit gives a registered word one cycle later; a miss refills from memory and bypasses the word.
module icache_direct #(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned ADDR_BITS  = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [31:0]            pc_in,
  input  logic                   stall_in,
  input  logic                   hold,
  input  logic                   jp_wrong,
  output logic                   ins_flag,
  output logic [31:0]            ins,
  icache_direct_if.master        mem
);

  localparam int unsigned Lines   = 2 ** INDEX_BITS;
  localparam int unsigned TagBits = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {StIdle, StFetch, StDrop} state_e;

  state_e                  state_q, state_d;
  logic                    ins_flag_q, ins_flag_d;
  logic [31:0]             ins_q, ins_d;
  logic                    req_q, req_d;
  logic [31:0]             addr_q, addr_d;
  logic [INDEX_BITS-1:0]   fill_idx_q, fill_idx_d;
  logic [TagBits-1:0]      fill_tag_q, fill_tag_d;
  logic                    fill_we;

  logic [Lines-1:0]        valid_q;
  logic [TagBits-1:0]      tag_arr_q  [Lines];
  logic [31:0]             data_arr_q [Lines];

  logic [INDEX_BITS-1:0]   idx;
  logic [TagBits-1:0]      tag;
  logic                    hit;
  logic                    unused_pc_bits;

  assign idx            = pc_in[INDEX_BITS+1:2];
  assign tag            = pc_in[ADDR_BITS-1:INDEX_BITS+2];
  assign hit            = valid_q[idx] && (tag_arr_q[idx] == tag);
  assign unused_pc_bits = ^pc_in[1:0];

  always_comb begin
    state_d    = state_q;
    ins_flag_d = ins_flag_q;
    ins_d      = ins_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    fill_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (jp_wrong) begin
          ins_flag_d = 1'b0;
        end else if (hold) begin
          // Decoder stalled: keep the delivered word on the outputs.
        end else if (stall_in) begin
          ins_flag_d = 1'b0;
        end else if (hit) begin
          ins_flag_d = 1'b1;
          ins_d      = data_arr_q[idx];
        end else begin
          ins_flag_d = 1'b0;
          req_d      = 1'b1;
          addr_d     = {pc_in[31:2], 2'b00};
          fill_idx_d = idx;
          fill_tag_d = tag;
          state_d    = StFetch;
        end
      end

      StFetch: begin
        if (mem.mem_done) begin
          fill_we = 1'b1;
          req_d   = 1'b0;
          state_d = StIdle;
          if (!jp_wrong && !hold) begin
            ins_flag_d = 1'b1;
            ins_d      = mem.mem_data;
          end
        end else if (jp_wrong) begin
          // Abandon delivery but keep the request up until memory answers.
          state_d = StDrop;
        end
      end

      StDrop: begin
        if (mem.mem_done) begin
          fill_we = 1'b1;
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ins_flag_q <= 1'b0;
      ins_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      valid_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      ins_flag_q <= ins_flag_d;
      ins_q      <= ins_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      if (fill_we) begin
        valid_q[fill_idx_q] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset; valid bits gate every read.
  always_ff @(posedge clk) begin
    if (rdy && fill_we) begin
      tag_arr_q[fill_idx_q]  <= fill_tag_q;
      data_arr_q[fill_idx_q] <= mem.mem_data;
    end
  end

  assign ins_flag     = ins_flag_q;
  assign ins          = ins_q;
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: a queue of expected instruction words is
// pushed when a fetch is driven and popped when the cache delivers.
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_in;
  logic        stall_in;
  logic        hold;
  logic        jp_wrong;
  logic        ins_flag;
  logic [31:0] ins;

  icache_direct_if mem_bus ();

  icache_direct #(
    .INDEX_BITS (8),
    .ADDR_BITS  (18)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .pc_in    (pc_in),
    .stall_in (stall_in),
    .hold     (hold),
    .jp_wrong (jp_wrong),
    .ins_flag (ins_flag),
    .ins      (ins),
    .mem      (mem_bus)
  );

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the next expected word and compare it with what the cache is presenting.
  task automatic take_out(input string tag);
    logic [31:0] exp_w;
    exp_w = exp_q.pop_front();
    check_val({tag, "_flag"}, ins_flag, 1);
    check_val({tag, "_ins"}, ins, exp_w);
  endtask

  // Present pc; on a miss, answer the refill lat cycles after mem_req rises.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] word, input bit miss,
                       input int lat);
    pc_in = pc;
    exp_q.push_back(word);
    tick();
    if (miss) begin
      check_val("miss_req", mem_bus.mem_req, 1);
      check_val("miss_addr", mem_bus.mem_addr, {pc[31:2], 2'b00});
      check_val("miss_flag", ins_flag, 0);
      for (int i = 1; i < lat; i++) begin
        tick();
        check_val("req_held", mem_bus.mem_req, 1);
        check_val("addr_stable", mem_bus.mem_addr, {pc[31:2], 2'b00});
      end
      mem_bus.mem_done = 1'b1;
      mem_bus.mem_data = word;
      tick();
      mem_bus.mem_done = 1'b0;
      mem_bus.mem_data = $urandom;
      check_val("req_fall", mem_bus.mem_req, 0);
      take_out("refill");
    end else begin
      check_val("hit_noreq", mem_bus.mem_req, 0);
      take_out("hit");
    end
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    rdy              = 1'b1;
    pc_in            = '0;
    stall_in         = 1'b0;
    hold             = 1'b0;
    jp_wrong         = 1'b0;
    mem_bus.mem_done = 1'b0;
    mem_bus.mem_data = '0;
    #1 rst = 1'b0;
    #1;
    check_val("rst_flag", ins_flag, 0);
    check_val("rst_ins", ins, 0);
    check_val("rst_req", mem_bus.mem_req, 0);
    check_val("rst_addr", mem_bus.mem_addr, 0);
    tick();
    tick();
    rst = 1'b1;

    // Cold miss, then hit on the same pc.
    fetch(32'h0000_0000, 32'h0000_0513, 1, 4);
    fetch(32'h0000_0000, 32'h0000_0513, 0, 0);

    // Conflict eviction and index wrap.
    fetch(32'h0000_0400, 32'h1111_0400, 1, 2);
    fetch(32'h0000_0000, 32'h0000_0513, 1, 3);
    fetch(32'h0000_03FC, 32'h3FC0_FFEE, 1, 1);
    fetch(32'h0000_03FC, 32'h3FC0_FFEE, 0, 0);
    fetch(32'h0000_0000, 32'h0000_0513, 0, 0);

    // Flush mid-refill: request survives, word is filled but not delivered.
    pc_in = 32'h0000_0010;
    tick();
    check_val("fl_req", mem_bus.mem_req, 1);
    check_val("fl_addr", mem_bus.mem_addr, 32'h10);
    jp_wrong = 1'b1;
    tick();
    check_val("drop_req", mem_bus.mem_req, 1);
    check_val("drop_flag", ins_flag, 0);
    tick();
    check_val("drop_req2", mem_bus.mem_req, 1);
    check_val("drop_flag2", ins_flag, 0);
    jp_wrong         = 1'b0;
    mem_bus.mem_done = 1'b1;
    mem_bus.mem_data = 32'hDEAD_BEEF;
    tick();
    mem_bus.mem_done = 1'b0;
    check_val("drop_done_flag", ins_flag, 0);
    check_val("drop_done_req", mem_bus.mem_req, 0);
    fetch(32'h0000_0010, 32'hDEAD_BEEF, 0, 0);

    // Flush coincident with done.
    pc_in = 32'h0000_0020;
    tick();
    check_val("co_req", mem_bus.mem_req, 1);
    tick();
    mem_bus.mem_done = 1'b1;
    mem_bus.mem_data = 32'hCAFE_F00D;
    jp_wrong         = 1'b1;
    tick();
    mem_bus.mem_done = 1'b0;
    jp_wrong         = 1'b0;
    check_val("co_flag", ins_flag, 0);
    check_val("co_req_fall", mem_bus.mem_req, 0);
    fetch(32'h0000_0020, 32'hCAFE_F00D, 0, 0);

    // Stall on a hitting pc.
    pc_in    = 32'h0000_0000;
    stall_in = 1'b1;
    tick();
    check_val("stall_flag", ins_flag, 0);
    check_val("stall_req", mem_bus.mem_req, 0);
    stall_in = 1'b0;
    fetch(32'h0000_0000, 32'h0000_0513, 0, 0);

    // Hold keeps the delivered word even while pc would miss.
    fetch(32'h0000_0040, 32'h00A0_0093, 1, 2);
    hold  = 1'b1;
    pc_in = 32'h0000_0044;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("hold_flag", ins_flag, 1);
      check_val("hold_ins", ins, 32'h00A0_0093);
      check_val("hold_req", mem_bus.mem_req, 0);
    end
    pc_in = 32'h0000_0040;
    hold  = 1'b0;

    // rdy=0 freezes everything, in IDLE and in FETCH.
    rdy   = 1'b0;
    pc_in = 32'h0000_0080;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rdy_flag", ins_flag, 1);
      check_val("rdy_ins", ins, 32'h00A0_0093);
      check_val("rdy_req", mem_bus.mem_req, 0);
    end
    rdy = 1'b1;
    exp_q.push_back(32'h0808_0808);
    tick();
    check_val("rdy_miss_req", mem_bus.mem_req, 1);
    check_val("rdy_miss_addr", mem_bus.mem_addr, 32'h80);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("rdy_fetch_req", mem_bus.mem_req, 1);
      check_val("rdy_fetch_addr", mem_bus.mem_addr, 32'h80);
    end
    rdy              = 1'b1;
    mem_bus.mem_done = 1'b1;
    mem_bus.mem_data = 32'h0808_0808;
    tick();
    mem_bus.mem_done = 1'b0;
    take_out("rdy_refill");

    // Asynchronous reset mid-FETCH; filled lines are forgotten.
    pc_in = 32'h0000_0100;
    tick();
    check_val("ar_req", mem_bus.mem_req, 1);
    #2 rst = 1'b0;
    #1;
    check_val("ar_req_fall", mem_bus.mem_req, 0);
    check_val("ar_flag", ins_flag, 0);
    check_val("ar_addr", mem_bus.mem_addr, 0);
    tick();
    rst = 1'b1;
    fetch(32'h0000_0000, 32'h0000_0513, 1, 2);

    check_val("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
